// File: rtl/rsa_pkg.sv
// Purpose : shared RSA datapath definitions (operand width default, control state
//           enum, Montgomery per-bit step) used by the modulo-product, Montgomery
//           and exponentiation stages.
// Latency : n/a (package).  Backpressure: n/a (package).
package rsa_pkg;

    // Default modulus/operand width across the RSA stages.
    localparam int RSA_WIDTH = 256;

    // Accumulator width for the widest supported operand. With m < 2N, B < N and
    // N < 2^W, the worst intermediate m + B + N stays below 4N < 2^(W+2).
    localparam int RSA_ACC_W = RSA_WIDTH + 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_SUB
    } rsa_state_t;

    // One radix-2 Montgomery iteration:
    //   m += a_bit ? B : 0;  m += m odd ? N : 0;  m >>= 1.
    // Adding N when m is odd makes m even, so the shift divides exactly by 2 mod N.
    // Narrower instances zero-extend into this width and truncate the result;
    // the upper bits then stay zero and synthesis trims them away.
    function automatic logic [RSA_ACC_W-1:0] mont_step(
        input logic [RSA_ACC_W-1:0] m,
        input logic                 a_bit,
        input logic [RSA_ACC_W-1:0] b,
        input logic [RSA_ACC_W-1:0] n
    );
        logic [RSA_ACC_W-1:0] t;
        t = a_bit ? (m + b) : m;
        if (t[0]) begin
            t = t + n;
        end
        return t >> 1;
    endfunction

endpackage

// File: rtl/rsa_montgomery.sv
// Purpose : bit-serial Montgomery multiplier, o_result = A*B*2^-WIDTH mod N.
// Latency : o_finish pulses WIDTH+1 edges after the edge that samples i_start.
// Backpr. : none; i_start is honoured only while idle (including the o_finish
//           cycle) and ignored while busy, so requests made while busy are dropped.
//
// Ports:
//   i_clk    rising-edge clock
//   i_rst    asynchronous active-high reset
//   i_start  one-cycle request, sampled only when idle
//   i_n      modulus N (odd), latched at start
//   i_a      multiplicand A (< N), latched at start
//   i_b      multiplier B (< N), latched at start
//   o_result A*B*2^-WIDTH mod N, held until the next completion
//   o_finish one-cycle completion pulse, coincident with o_result update
//
// WIDTH may not exceed rsa_pkg::RSA_WIDTH: the per-bit step is sized for it.
module rsa_montgomery
    import rsa_pkg::*;
#(
    parameter int WIDTH = RSA_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_n,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_result,
    output logic             o_finish
);

    localparam int ACC_W = WIDTH + 2;
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    rsa_state_t       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [ACC_W-1:0] m_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] n_q;
    logic [WIDTH-1:0] result_q;
    logic             finish_q;

    logic [ACC_W-1:0] m_step_d;
    logic [WIDTH-1:0] result_d;

    // Next accumulator value for the current multiplicand bit, and the final
    // conditional subtraction that brings m (< 2N) into [0, N).
    always_comb begin
        m_step_d = ACC_W'(mont_step(RSA_ACC_W'(m_q), a_q[cnt_q],
                                    RSA_ACC_W'(b_q), RSA_ACC_W'(n_q)));
        result_d = '0;
        if (m_q >= {2'b00, n_q}) begin
            result_d = WIDTH'(m_q - {2'b00, n_q});
        end else begin
            result_d = WIDTH'(m_q);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            m_q      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            n_q      <= '0;
            result_q <= '0;
            finish_q <= 1'b0;
        end else begin
            // o_finish is a single-cycle pulse; only S_SUB raises it.
            finish_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        a_q     <= i_a;
                        b_q     <= i_b;
                        n_q     <= i_n;
                        m_q     <= '0;
                        cnt_q   <= '0;
                        state_q <= S_CALC;
                    end
                end
                S_CALC: begin
                    m_q   <= m_step_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_q <= S_SUB;
                    end
                end
                S_SUB: begin
                    result_q <= result_d;
                    finish_q <= 1'b1;
                    state_q  <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign o_result = result_q;
    assign o_finish = finish_q;

endmodule

// File: tb/tb_rsa_montgomery.sv
// Purpose : self-checking bench for rsa_montgomery at WIDTH=8 (directed, hand-computed
//           vectors) and WIDTH=256 (random operands, back-to-back starts).
// Latency : checks o_finish at WIDTH+1 edges after the start edge.
// Backpr. : n/a.
module tb_rsa_montgomery;

    localparam logic [255:0] N256 = {256{1'b1}} - 256'd188;  // 2^256 - 189
    localparam int NVEC = 50;

    logic         clk;
    logic         rst;

    logic         start8;
    logic [7:0]   n8, a8, b8, res8;
    logic         fin8;

    logic         start256;
    logic [255:0] n256, a256, b256, res256;
    logic         fin256;

    int n_checks = 0;
    int n_fail   = 0;

    logic [255:0] av [NVEC];
    logic [255:0] bv [NVEC];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    rsa_montgomery #(.WIDTH(8)) u_dut8 (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_start  (start8),
        .i_n      (n8),
        .i_a      (a8),
        .i_b      (b8),
        .o_result (res8),
        .o_finish (fin8)
    );

    rsa_montgomery #(.WIDTH(256)) u_dut256 (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_start  (start256),
        .i_n      (n256),
        .i_a      (a256),
        .i_b      (b256),
        .o_result (res256),
        .o_finish (fin256)
    );

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // One 8-bit operation. Operand inputs are scrambled right after the start
    // edge; with hold=1 i_start stays high until o_finish is seen.
    task automatic run8(input string tag, input logic [7:0] n, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] exp, input bit hold);
        int         lat;
        int         extra;
        logic [7:0] prev;
        prev   = res8;
        n8     = n;
        a8     = a;
        b8     = b;
        start8 = 1'b1;
        @(posedge clk); #1;
        if (!hold) start8 = 1'b0;
        n8 = 8'hFF;
        a8 = 8'hA5;
        b8 = 8'h3C;
        lat = 0;
        while (!fin8 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 4) chk({tag, " held"}, res8, prev);
        end
        start8 = 1'b0;
        chk({tag, " lat"}, lat, 9);
        chk({tag, " res"}, res8, exp);
        extra = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (fin8) extra++;
        end
        chk({tag, " extra pulses"}, extra, 0);
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        if (r >= N256) r = r - N256;
        return r;
    endfunction

    initial begin
        int           lat;
        int           pulses;
        logic [255:0] got;
        logic [511:0] obs;
        logic [511:0] exp;

        rst      = 1'b0;
        start8   = 1'b0;
        n8       = '0;
        a8       = '0;
        b8       = '0;
        start256 = 1'b0;
        n256     = '0;
        a256     = '0;
        b256     = '0;
        #1 rst = 1'b1;
        #20;
        chk("reset res8", res8, 0);
        chk("reset fin8", fin8, 0);
        chk("reset res256", res256, 0);
        chk("reset fin256", fin256, 0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        // N=13, R=256 = 9 mod 13, R^-1 = 3 mod 13.
        run8("5x7",  8'd13, 8'd5,  8'd7,  8'd1, 1'b0);  // 35=9, 9*3=27=1
        run8("12x12", 8'd13, 8'd12, 8'd12, 8'd3, 1'b0); // 144=1, 1*3=3
        run8("0x9 hold", 8'd13, 8'd0, 8'd9, 8'd0, 1'b1);
        run8("1x1",  8'd13, 8'd1,  8'd1,  8'd3, 1'b0);

        // Reset at the 4th edge after the start edge aborts the run.
        n8 = 8'd13; a8 = 8'd5; b8 = 8'd7; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("pre-rst res8", res8, 3);
        rst = 1'b1;
        #1;
        chk("rst res8", res8, 0);
        chk("rst fin8", fin8, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        pulses = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (fin8) pulses++;
        end
        chk("rst no pulse", pulses, 0);
        run8("rerun 5x7", 8'd13, 8'd5, 8'd7, 8'd1, 1'b0);

        // WIDTH=256: result*2^256 mod N must equal A*B mod N, with result < N.
        for (int k = 0; k < NVEC; k++) begin
            av[k] = rnd256();
            bv[k] = rnd256();
        end
        av[0] = N256 - 256'd1;
        bv[0] = N256 - 256'd1;

        n256 = N256; a256 = av[0]; b256 = bv[0]; start256 = 1'b1;
        @(posedge clk); #1;
        start256 = 1'b0; a256 = '0; b256 = '0;
        for (int k = 0; k < NVEC; k++) begin
            lat = 0;
            while (!fin256 && lat < 300) begin
                @(posedge clk); #1;
                lat++;
            end
            got = res256;
            if (k < NVEC - 1) begin
                a256 = av[k+1]; b256 = bv[k+1]; start256 = 1'b1;
            end
            chk($sformatf("v%0d lat", k), lat, 257);
            chk($sformatf("v%0d range", k), (got < N256), 1);
            obs = {got, 256'b0} % {256'b0, N256};
            exp = ({256'b0, av[k]} * {256'b0, bv[k]}) % {256'b0, N256};
            chk($sformatf("v%0d value", k), obs, exp);
            if (k < NVEC - 1) begin
                @(posedge clk); #1;
                start256 = 1'b0; a256 = '0; b256 = '0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rsa_montgomery.md
RSA_MONTGOMERY -- requirements
Module: rsa_montgomery

Interface
REQ-001 The block SHALL have parameter WIDTH, default 256, giving the modulus/operand bit width (bench also uses 8).
REQ-002 The block SHALL have port i_clk, input, 1, rising-edge clock.
REQ-003 The block SHALL have port i_rst, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port i_start, input, 1, one-cycle request, sampled only in S_IDLE.
REQ-005 The block SHALL have port i_n, input, WIDTH, modulus N (odd).
REQ-006 The block SHALL have port i_a, input, WIDTH, multiplicand A (< N); the modulo-product stage output truncated to WIDTH connects here.
REQ-007 The block SHALL have port i_b, input, WIDTH, multiplier B (< N).
REQ-008 The block SHALL have port o_result, output, WIDTH, A*B*2^-WIDTH mod N.
REQ-009 The block SHALL have port o_finish, output, 1, one-cycle completion pulse.

Function
REQ-010 The block SHALL have states S_IDLE, S_CALC and S_SUB.
REQ-011 In S_IDLE, i_start=1 SHALL latch i_a, i_n and i_b, clear the accumulator m and counter, and move to S_CALC on the same edge.
REQ-012 The S_CALC edge with counter i SHALL compute m = m + (A[i] ? B : 0), then m = m + (m odd ? N : 0), then m = m >> 1.
REQ-013 The counter SHALL increment each S_CALC edge, and the edge with i = WIDTH-1 SHALL also move to S_SUB.
REQ-014 Accumulator m SHALL be WIDTH+2 bits wide so that no intermediate overflow occurs.
REQ-015 The S_SUB edge SHALL write o_result = (m >= N) ? m-N : m, truncated to WIDTH, set o_finish=1, and return to S_IDLE.
REQ-016 o_finish SHALL be high for exactly one cycle, following the edge at WIDTH+1 edges after the start-sampling edge (257 for WIDTH=256).
REQ-017 o_result SHALL hold its last value between completions and SHALL change only on the S_SUB edge.
REQ-018 i_start SHALL be ignored in S_CALC and S_SUB, and input changes after the latch edge SHALL have no effect.
REQ-019 i_start high in the cycle o_finish is high SHALL be accepted, since the state is S_IDLE, with no bubble required.
REQ-020 With even N or operands >= N, the latency SHALL be unchanged and o_result is unspecified.

Reset
REQ-021 i_rst SHALL asynchronously force state=S_IDLE and counter=0, and SHALL clear m, the latched operands, o_result and o_finish to 0.
REQ-022 Reset mid-operation SHALL abort the operation with no o_finish pulse, and the first start after reset SHALL run the full latency.

Structure
REQ-023 Package rsa_pkg SHALL hold the WIDTH default constant and the state enum, which are shared with the modulo-product and exponentiation stages.
REQ-024 The block SHALL be a single module with no sub-module, and the per-bit step SHALL be a function in rsa_pkg.

Verification
REQ-025 WIDTH=8, N=13, A=5, B=7, start -> o_finish exactly 9 edges later with o_result=1.
REQ-026 WIDTH=8, N=13, A=12, B=12 (exercises the final subtraction) -> o_result=3, and A=1, B=1 -> o_result=3.
REQ-027 WIDTH=8, N=13, A=0, B=9 -> o_result=0 with finish latency unchanged, and a start held high during the run -> still exactly one o_finish pulse.
REQ-028 WIDTH=8, assert i_rst at edge 4 of a run -> o_result=0 and o_finish=0 immediately with no pulse, then a new run with N=13, A=5, B=7 -> o_result=1.
REQ-029 WIDTH=256, N=2^256-189, 50 random A and B < N compared against a model of A*B*2^-256 mod N -> all match, each at latency 257, with back-to-back starts on the finish cycle.
